muladd_driver: RTL and testbench

MULADD_DRIVER -- requirements
Module: muladd_driver

---
 rtl/muladd_pkg.sv | 25 ++
 rtl/op_fifo.sv | 60 ++++++
 rtl/muladd_driver.sv | 145 ++++++++++++++
 tb/tb_muladd_driver.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muladd_pkg.sv
// Shared types and constants for the muladd driver slice.
package muladd_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned OP_W   = 3 * DATA_W;
    localparam int unsigned TMO_W  = 8;
    localparam int unsigned TAG_W  = 4;

    // Result substituted when the muladd never answers.
    localparam logic [DATA_W-1:0] TMO_RESULT = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DELIVER
    } drv_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] c;
    } operands_t;

endpackage

// File: rtl/op_fifo.sv
// First-word fall-through operand FIFO; head is valid whenever not empty.
module op_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 24
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;
    assign full_o  = (r_count == CW'(DEPTH));
    assign empty_o = (r_count == '0);
    assign head_o  = r_mem[r_rd_ptr];

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data_i;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push/pop keeps count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/muladd_driver.sv
// Queues operand triples and drives them one at a time through an external
// muladd unit, returning tagged results with a watchdog on the response.
module muladd_driver
    import muladd_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [DATA_W-1:0] cmd_a_i,
    input  logic [DATA_W-1:0] cmd_b_i,
    input  logic [DATA_W-1:0] cmd_c_i,
    output logic              mul_valid_o,
    input  logic              mul_ready_i,
    output logic [DATA_W-1:0] mul_a_o,
    output logic [DATA_W-1:0] mul_b_o,
    output logic [DATA_W-1:0] mul_c_o,
    input  logic              res_valid_i,
    output logic              res_ready_o,
    input  logic [DATA_W-1:0] res_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [TAG_W-1:0]  out_tag_o,
    output logic              busy_o,
    output logic              err_o
);

    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT);

    drv_state_t        r_state;
    logic              r_mul_valid;
    logic              r_res_ready;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_result;
    logic [TMO_W-1:0]  r_tmo_cnt;
    logic [TAG_W-1:0]  r_tag;
    logic              r_err;

    operands_t         w_push_ops;
    operands_t         w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;

    assign w_push_ops = '{a: cmd_a_i, b: cmd_b_i, c: cmd_c_i};
    assign w_push     = cmd_valid_i && cmd_ready_o;
    assign w_pop      = r_mul_valid && mul_ready_i;

    op_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (OP_W)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (w_push),
        .push_data_i (w_push_ops),
        .pop_i       (w_pop),
        .head_o      (w_head),
        .full_o      (w_full),
        .empty_o     (w_empty)
    );

    // Ready is forced low while reset is held so nothing is accepted then.
    assign cmd_ready_o = !w_full && !rst_i;

    assign mul_valid_o = r_mul_valid;
    assign mul_a_o     = r_mul_valid ? w_head.a : '0;
    assign mul_b_o     = r_mul_valid ? w_head.b : '0;
    assign mul_c_o     = r_mul_valid ? w_head.c : '0;
    assign res_ready_o = r_res_ready;
    assign out_valid_o = r_out_valid;
    assign out_data_o  = r_out_valid ? r_result : '0;
    assign out_tag_o   = r_out_valid ? r_tag : '0;
    assign busy_o      = !w_empty || (r_state != ST_IDLE);
    assign err_o       = r_err;

    // Sequencer: the handshake flags are registered alongside the state so
    // each is high exactly while its state is current.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_mul_valid <= 1'b0;
            r_res_ready <= 1'b0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_tmo_cnt   <= '0;
            r_tag       <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_state     <= ST_ISSUE;
                        r_mul_valid <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (mul_ready_i) begin
                        r_state     <= ST_WAIT;
                        r_mul_valid <= 1'b0;
                        r_res_ready <= 1'b1;
                        r_tmo_cnt   <= '0;
                    end
                end
                ST_WAIT: begin
                    if (res_valid_i) begin
                        r_result    <= res_data_i;
                        r_state     <= ST_DELIVER;
                        r_res_ready <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_tmo_cnt   <= '0;
                    end else if (r_tmo_cnt + TMO_W'(1) == TMO_LIMIT) begin
                        r_result    <= TMO_RESULT;
                        r_err       <= 1'b1;
                        r_state     <= ST_DELIVER;
                        r_res_ready <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_tmo_cnt   <= '0;
                    end else begin
                        r_tmo_cnt   <= r_tmo_cnt + TMO_W'(1);
                    end
                end
                ST_DELIVER: begin
                    if (out_ready_i) begin
                        r_tag       <= r_tag + TAG_W'(1);
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_mul_valid <= 1'b0;
                    r_res_ready <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muladd_driver.sv
// Directed bench for muladd_driver with a behavioural muladd responder.
module tb_muladd_driver;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       cmd_valid_i;
    logic       cmd_ready_o;
    logic [7:0] cmd_a_i, cmd_b_i, cmd_c_i;
    logic       mul_valid_o;
    logic       mul_ready_i;
    logic [7:0] mul_a_o, mul_b_o, mul_c_o;
    logic       res_valid_i = 1'b0;
    logic       res_ready_o;
    logic [7:0] res_data_i = 8'd0;
    logic       out_valid_o;
    logic       out_ready_i;
    logic [7:0] out_data_o;
    logic [3:0] out_tag_o;
    logic       busy_o;
    logic       err_o;

    int vectors     = 0;
    int miscompares = 0;

    // Responder controls
    logic       model_en    = 1'b1;
    int         model_delay = 0;
    int         wcnt        = 0;
    logic [7:0] la = 8'd0, lb = 8'd0, lc = 8'd0;

    always #5 clk = ~clk;

    muladd_driver #(
        .DEPTH   (4),
        .TIMEOUT (15)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_a_i     (cmd_a_i),
        .cmd_b_i     (cmd_b_i),
        .cmd_c_i     (cmd_c_i),
        .mul_valid_o (mul_valid_o),
        .mul_ready_i (mul_ready_i),
        .mul_a_o     (mul_a_o),
        .mul_b_o     (mul_b_o),
        .mul_c_o     (mul_c_o),
        .res_valid_i (res_valid_i),
        .res_ready_o (res_ready_o),
        .res_data_i  (res_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_tag_o   (out_tag_o),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    // Muladd responder: latches issued operands, answers after model_delay
    // extra wait cycles, or never when disabled.
    always @(negedge clk) begin
        if (mul_valid_o) begin
            la = mul_a_o;
            lb = mul_b_o;
            lc = mul_c_o;
        end
        if (res_ready_o) wcnt = wcnt + 1;
        else             wcnt = 0;
        res_valid_i = model_en && res_ready_o && (wcnt > model_delay);
        res_data_i  = res_valid_i ? 8'(la * lb + lc) : 8'd0;
    end

    task automatic do_reset();
        rst_i       = 1'b1;
        cmd_valid_i = 1'b0;
        out_ready_i = 1'b0;
        mul_ready_i = 1'b1;
        model_en    = 1'b1;
        model_delay = 0;
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_cmd(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, output bit to);
        cmd_a_i     = a;
        cmd_b_i     = b;
        cmd_c_i     = c;
        cmd_valid_i = 1'b1;
        to          = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (cmd_ready_o) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_out(output logic [7:0] d, output logic [3:0] t,
                            output int lat, output bit to);
        to  = 1'b1;
        lat = 0;
        d   = 8'd0;
        t   = 4'd0;
        for (int i = 0; i < 200; i++) begin
            if (out_valid_o) begin
                d  = out_data_o;
                t  = out_tag_o;
                to = 1'b0;
                break;
            end
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic accept_out();
        out_ready_i = 1'b1;
        @(negedge clk);
        out_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        bit to;
        rst_i = 1'b1; cmd_valid_i = 1'b0; out_ready_i = 1'b0; mul_ready_i = 1'b1;
        cmd_a_i = 8'd0; cmd_b_i = 8'd0; cmd_c_i = 8'd0;
        @(negedge clk);
        @(negedge clk);
        vectors++; if (cmd_ready_o !== 1'b0) begin miscompares++; $display("FAIL rst_cmd_ready: got %b expected 0", cmd_ready_o); end
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b expected 0", busy_o); end
        vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL rst_err: got %b expected 0", err_o); end
        vectors++; if ({mul_valid_o, res_ready_o, out_valid_o} !== 3'b000) begin miscompares++; $display("FAIL rst_valids: got %b expected 000", {mul_valid_o, res_ready_o, out_valid_o}); end
        vectors++; if ({out_data_o, out_tag_o, mul_a_o} !== 20'd0) begin miscompares++; $display("FAIL rst_data: got %h expected 0", {out_data_o, out_tag_o, mul_a_o}); end
        rst_i = 1'b0;
        #1;
        vectors++; if (cmd_ready_o !== 1'b1) begin miscompares++; $display("FAIL rel_cmd_ready: got %b expected 1", cmd_ready_o); end
        @(negedge clk);
        // Asynchronous assertion between clock edges
        send_cmd(8'd1, 8'd1, 8'd1, to);
        vectors++; if (busy_o !== 1'b1) begin miscompares++; $display("FAIL pre_async_busy: got %b expected 1", busy_o); end
        #2 rst_i = 1'b1;
        #1;
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL async_busy: got %b expected 0", busy_o); end
        vectors++; if (cmd_ready_o !== 1'b0) begin miscompares++; $display("FAIL async_cmd_ready: got %b expected 0", cmd_ready_o); end
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        bit to; logic [7:0] d; logic [3:0] t; int lat;
        do_reset();
        send_cmd(8'd3, 8'd4, 8'd5, to);
        vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL single_accept: got timeout=%b expected 0", to); end
        wait_out(d, t, lat, to);
        vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL single_out_timeout: got %b expected 0", to); end
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL single_latency: got %0d expected 3", lat); end
        vectors++; if (d !== 8'd17) begin miscompares++; $display("FAIL single_data: got %0d expected 17", d); end
        vectors++; if (t !== 4'd0) begin miscompares++; $display("FAIL single_tag: got %0d expected 0", t); end
        vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL single_err: got %b expected 0", err_o); end
        vectors++; if ({la, lb, lc} !== {8'd3, 8'd4, 8'd5}) begin miscompares++; $display("FAIL single_issue_ops: got %h expected 030405", {la, lb, lc}); end
        accept_out();
        vectors++; if ({out_valid_o, out_data_o, out_tag_o, busy_o} !== 14'd0) begin miscompares++; $display("FAIL single_idle_outs: got %h expected 0", {out_valid_o, out_data_o, out_tag_o, busy_o}); end
    endtask

    task automatic test_burst();
        bit to; logic [7:0] d; logic [3:0] t; int lat;
        logic [7:0] ta [5] = '{8'd1, 8'd10, 8'd16, 8'd255, 8'd0};
        logic [7:0] tb [5] = '{8'd2, 8'd20, 8'd16, 8'd255, 8'd99};
        logic [7:0] tc [5] = '{8'd3, 8'd30, 8'd7, 8'd1, 8'd200};
        logic [7:0] te [5] = '{8'd5, 8'd230, 8'd7, 8'd2, 8'd200};
        do_reset();
        mul_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            send_cmd(ta[k], tb[k], tc[k], to);
            vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL burst_accept%0d: got timeout=%b expected 0", k, to); end
        end
        cmd_a_i = ta[4]; cmd_b_i = tb[4]; cmd_c_i = tc[4]; cmd_valid_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            vectors++; if (cmd_ready_o !== 1'b0) begin miscompares++; $display("FAIL burst_full_ready%0d: got %b expected 0", k, cmd_ready_o); end
            @(negedge clk);
        end
        vectors++; if ({mul_valid_o, mul_a_o} !== {1'b1, 8'd1}) begin miscompares++; $display("FAIL burst_head: got %h expected 101", {mul_valid_o, mul_a_o}); end
        mul_ready_i = 1'b1;
        send_cmd(ta[4], tb[4], tc[4], to);
        vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL burst_accept4: got timeout=%b expected 0", to); end
        for (int k = 0; k < 5; k++) begin
            wait_out(d, t, lat, to);
            vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL burst_out_timeout%0d: got %b expected 0", k, to); end
            vectors++; if (d !== te[k]) begin miscompares++; $display("FAIL burst_data%0d: got %0d expected %0d", k, d, te[k]); end
            vectors++; if (t !== 4'(k)) begin miscompares++; $display("FAIL burst_tag%0d: got %0d expected %0d", k, t, k); end
            accept_out();
        end
    endtask

    task automatic test_backpressure();
        bit to; logic [7:0] d; logic [3:0] t; int lat; int bad;
        do_reset();
        send_cmd(8'd7, 8'd8, 8'd9, to);
        wait_out(d, t, lat, to);
        vectors++; if (d !== 8'd65) begin miscompares++; $display("FAIL bp_data: got %0d expected 65", d); end
        send_cmd(8'd2, 8'd2, 8'd2, to);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (out_valid_o !== 1'b1 || out_data_o !== 8'd65 || out_tag_o !== 4'd0 || mul_valid_o !== 1'b0) bad++;
            @(negedge clk);
        end
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL bp_hold_stable: got %0d unstable cycles expected 0", bad); end
        vectors++; if (busy_o !== 1'b1) begin miscompares++; $display("FAIL bp_busy: got %b expected 1", busy_o); end
        accept_out();
        wait_out(d, t, lat, to);
        vectors++; if ({d, t} !== {8'd6, 4'd1}) begin miscompares++; $display("FAIL bp_second: got %h expected 061", {d, t}); end
        accept_out();
    endtask

    task automatic test_timeout();
        bit to; logic [7:0] d; logic [3:0] t; int lat; int nwait;
        do_reset();
        model_en = 1'b0;
        send_cmd(8'd1, 8'd1, 8'd1, to);
        nwait = 0;
        to = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (out_valid_o) begin to = 1'b0; break; end
            if (res_ready_o) nwait++;
            if (nwait == 14) begin
                vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL tmo_err_early: got %b expected 0", err_o); end
            end
            @(negedge clk);
        end
        vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL tmo_no_deliver: got %b expected 0", to); end
        vectors++; if (nwait !== 15) begin miscompares++; $display("FAIL tmo_wait_cycles: got %0d expected 15", nwait); end
        vectors++; if (out_data_o !== 8'hFF) begin miscompares++; $display("FAIL tmo_data: got %h expected ff", out_data_o); end
        vectors++; if (err_o !== 1'b1) begin miscompares++; $display("FAIL tmo_err: got %b expected 1", err_o); end
        accept_out();
        model_en = 1'b1;
        send_cmd(8'd5, 8'd5, 8'd5, to);
        wait_out(d, t, lat, to);
        vectors++; if ({d, t} !== {8'd30, 4'd1}) begin miscompares++; $display("FAIL tmo_next_op: got %h expected 1e1", {d, t}); end
        vectors++; if (err_o !== 1'b1) begin miscompares++; $display("FAIL tmo_err_sticky: got %b expected 1", err_o); end
        accept_out();
        // Response arriving on the very cycle the watchdog expires
        do_reset();
        model_delay = 14;
        send_cmd(8'd9, 8'd9, 8'd9, to);
        wait_out(d, t, lat, to);
        vectors++; if (d !== 8'd90) begin miscompares++; $display("FAIL tmo_tie_data: got %0d expected 90", d); end
        vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL tmo_tie_err: got %b expected 0", err_o); end
        accept_out();
        model_delay = 0;
    endtask

    task automatic test_tag_wrap();
        bit to; logic [7:0] d; logic [3:0] t; int lat;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            send_cmd(8'(i), 8'd2, 8'd1, to);
            wait_out(d, t, lat, to);
            vectors++; if (d !== 8'(2 * i + 1)) begin miscompares++; $display("FAIL wrap_data%0d: got %0d expected %0d", i, d, 2 * i + 1); end
            vectors++; if (t !== 4'(i % 16)) begin miscompares++; $display("FAIL wrap_tag%0d: got %0d expected %0d", i, t, i % 16); end
            accept_out();
        end
    endtask

    task automatic test_reset_wait();
        bit to; logic [7:0] d; logic [3:0] t; int lat; int seen;
        do_reset();
        model_en = 1'b0;
        send_cmd(8'd1, 8'd1, 8'd1, to);
        send_cmd(8'd2, 8'd2, 8'd2, to);
        send_cmd(8'd3, 8'd3, 8'd3, to);
        repeat (3) @(negedge clk);
        vectors++; if ({res_ready_o, busy_o} !== 2'b11) begin miscompares++; $display("FAIL rw_in_wait: got %b expected 11", {res_ready_o, busy_o}); end
        #2 rst_i = 1'b1;
        #1;
        vectors++; if ({busy_o, res_ready_o} !== 2'b00) begin miscompares++; $display("FAIL rw_busy: got %b expected 00", {busy_o, res_ready_o}); end
        @(negedge clk);
        rst_i = 1'b0;
        model_en = 1'b1;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid_o || mul_valid_o) seen++;
        end
        vectors++; if (seen !== 0) begin miscompares++; $display("FAIL rw_dropped: got %0d active cycles expected 0", seen); end
        send_cmd(8'd6, 8'd7, 8'd8, to);
        wait_out(d, t, lat, to);
        vectors++; if ({d, t} !== {8'd50, 4'd0}) begin miscompares++; $display("FAIL rw_next: got %h expected 320", {d, t}); end
        accept_out();
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_backpressure();
        test_timeout();
        test_tag_wrap();
        test_reset_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule
